// File: rtl/if_id_queue.sv
// if_id_queue: instruction buffer between fetch and decode.
// A circular FIFO of (pc, inst) pairs feeds a registered output stage that
// supports decode stall, flush (branch redirect) and bubble insertion.
// The output stage reads as all zeros whenever it holds no instruction.
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN. When it is defined, a push
// into an empty FIFO while decode is not stalled goes straight to the output stage.
module if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [INST_WIDTH-1:0] if_inst,
  output logic                  if_ready,
  input  logic                  id_stall,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [CNT_W-1:0]      count
);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  id_valid_q, id_valid_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;

  logic full, fifo_empty, push, bypass, push_fifo, pop;

  // Handshake decode; fullness is judged on the registered count only, so a
  // same-cycle pop never frees a slot for a push.
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    fifo_empty = (count_q == '0);
    push       = if_valid && !full && !flush;
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass     = push && fifo_empty && !id_stall;
`else
    bypass     = 1'b0;
`endif
    push_fifo  = push && !bypass;
    pop        = !flush && !id_stall && !fifo_empty;
  end

  // Next-state for pointers, occupancy and the output stage; flush wins over all.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
    end else begin
      if (push_fifo) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_fifo) - CNT_W'(pop);
      if (!id_stall) begin
        if (!fifo_empty) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_mem[rd_ptr_q];
          id_inst_d  = inst_mem[rd_ptr_q];
`ifdef IF_ID_QUEUE_BYPASS_EN
        end else if (bypass) begin
          id_valid_d = 1'b1;
          id_pc_d    = if_pc;
          id_inst_d  = if_inst;
`endif
        end else begin
          id_valid_d = 1'b0;
          id_pc_d    = '0;
          id_inst_d  = '0;
        end
      end
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      inst_mem[wr_ptr_q] <= if_inst;
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign if_ready = !full;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=4, 32-bit pc/inst).
// Accepted pushes go into a scoreboard queue; every output-stage advance that
// should carry an instruction pops the scoreboard and compares.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             if_valid = 1'b0;
  logic [31:0]      if_pc = '0;
  logic [31:0]      if_inst = '0;
  logic             if_ready;
  logic             id_stall = 1'b0;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic [CNT_W-1:0] count;

  if_id_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  int          m_cnt = 0;
  logic        e_v = 1'b0;
  logic [31:0] e_pc = '0;
  logic [31:0] e_inst = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, predict, check after the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic st, input logic fl, output logic acc);
    logic push, byp, pushf, pop;
    logic [63:0] item;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_inst = inst; id_stall = st; flush = fl;
    #1;
    check_eq("if_ready", 64'(if_ready), 64'(m_cnt != DEPTH));
    push  = v && (m_cnt != DEPTH) && !fl;
    byp   = BYP && push && (m_cnt == 0) && !st;
    pushf = push && !byp;
    pop   = !fl && !st && (m_cnt > 0);
    acc   = push;
    if (push) sb.push_back({pc, inst});
    if (fl) begin
      sb.delete();
      m_cnt = 0;
      e_v = 1'b0; e_pc = '0; e_inst = '0;
    end else begin
      if (!st) begin
        if (m_cnt > 0 || byp) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
            e_v = 1'b0; e_pc = '0; e_inst = '0;
          end else begin
            item = sb.pop_front();
            e_v = 1'b1; e_pc = item[63:32]; e_inst = item[31:0];
          end
        end else begin
          e_v = 1'b0; e_pc = '0; e_inst = '0;
        end
      end
      m_cnt = m_cnt + int'(pushf) - int'(pop);
    end
    @(posedge clk);
    #1;
    check_eq("id_valid", 64'(id_valid), 64'(e_v));
    check_eq("id_pc", 64'(id_pc), 64'(e_pc));
    check_eq("id_inst", 64'(id_inst), 64'(e_inst));
    check_eq("count", 64'(count), 64'(m_cnt));
    check_eq("count_le_depth", 64'(int'(count) <= DEPTH), 64'd1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
  endtask

  initial begin
    logic        a;
    int          accepted;
    int          guard;
    logic [31:0] pcv;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_id_valid", 64'(id_valid), 64'd0);
    check_eq("rst_id_pc", 64'(id_pc), 64'd0);
    check_eq("rst_id_inst", 64'(id_inst), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_if_ready", 64'(if_ready), 64'd1);

    // Single push latency: 2 cycles, or 1 with bypass
    step(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0, a);
    check_eq("lat_first_edge", 64'(id_valid), 64'(BYP));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
    check_eq("lat_second_edge", 64'(id_valid), 64'(!BYP));
    check_eq("lat_second_pc", 64'(id_pc), BYP ? 64'h0 : 64'h100);
    idle(2);

    // Stalled fill: 5 pushes, 5th refused
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h200 + 32'(i * 4), 32'hA000 + 32'(i), 1'b1, 1'b0, a);
    check_eq("stall_count_full", 64'(count), 64'd4);
    check_eq("stall_if_ready", 64'(if_ready), 64'd0);
    idle(4);
    idle(1);
    check_eq("drain_bubble_v", 64'(id_valid), 64'd0);
    check_eq("drain_bubble_pc", 64'(id_pc), 64'd0);
    check_eq("drain_bubble_inst", 64'(id_inst), 64'd0);

    // Full queue, stall released with if_valid high: 20 instructions
    accepted = 0;
    pcv = 32'h1000;
    while (m_cnt < DEPTH) begin
      step(1'b1, pcv, ~pcv, 1'b1, 1'b0, a);
      if (a) begin accepted++; pcv += 4; end
    end
    step(1'b1, pcv, ~pcv, 1'b0, 1'b0, a);
    check_eq("full_refuse_count", 64'(count), 64'd3);
    if (a) begin accepted++; pcv += 4; end
    step(1'b1, pcv, ~pcv, 1'b0, 1'b0, a);
    check_eq("next_accept_count", 64'(count), 64'd3);
    if (a) begin accepted++; pcv += 4; end
    guard = 0;
    while (accepted < 20 && guard < 100) begin
      step(1'b1, pcv, ~pcv, 1'b0, 1'b0, a);
      if (a) begin accepted++; pcv += 4; end
      guard++;
    end
    check_eq("stream_20_done", 64'(accepted), 64'd20);
    idle(6);

    // Flush with count=3, output valid, concurrent push
    step(1'b1, 32'h3000, 32'h1, 1'b0, 1'b0, a);
    step(1'b1, 32'h3004, 32'h2, 1'b0, 1'b0, a);
    pcv = 32'h3008;
    guard = 0;
    while (m_cnt < 3 && guard < 10) begin
      step(1'b1, pcv, pcv, 1'b1, 1'b0, a);
      pcv += 4;
      guard++;
    end
    check_eq("preflush_count", 64'(count), 64'd3);
    check_eq("preflush_valid", 64'(id_valid), 64'd1);
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, a);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_valid", 64'(id_valid), 64'd0);
    check_eq("flush_pc", 64'(id_pc), 64'd0);
    idle(2);
    step(1'b1, 32'h4000, 32'h4, 1'b0, 1'b0, a);
    step(1'b1, 32'h4004, 32'h5, 1'b0, 1'b0, a);
    idle(3);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h5000 + 32'(i * 4), 32'h50 + 32'(i), 1'b1, 1'b0, a);
    step(1'b1, 32'h500C, 32'h53, 1'b0, 1'b0, a);
    @(negedge clk);
    if_valid = 1'b0; id_stall = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_id_valid", 64'(id_valid), 64'd0);
    check_eq("arst_id_pc", 64'(id_pc), 64'd0);
    check_eq("arst_id_inst", 64'(id_inst), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_if_ready", 64'(if_ready), 64'd1);
    #1 rst = 1'b0;
    sb.delete();
    m_cnt = 0;
    e_v = 1'b0; e_pc = '0; e_inst = '0;
    step(1'b1, 32'h6000, 32'h60, 1'b0, 1'b0, a);
    idle(3);

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom(), $urandom(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0), a);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
